rf_wb_scoreboard: RTL

//  Owns the single GPR write port and sequences all writes into it. Arbitrates between the
//  in-order pipeline WB and the long-latency unit (mul/div, load miss) result channel.

---
 rtl/rf_wb_scoreboard_if.sv | 48 ++++
 rtl/rf_wb_scoreboard.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/rf_wb_scoreboard_if.sv
// Bundle between ID/WB/long-unit and the GPR write sequencer.
// The master drives requests; the slave (the scoreboard) returns stalls, ready and the rf write port.
interface rf_wb_scoreboard_if #(
   parameter int RW = 5,
   parameter int W  = 32
);
   localparam int NREG = 2 ** RW;

   logic            id_issue;
   logic            id_rs_en;
   logic [RW-1:0]   id_rs_addr;
   logic            id_rt_en;
   logic [RW-1:0]   id_rt_addr;
   logic            id_wr;
   logic [RW-1:0]   id_rd_addr;
   logic            id_long;
   logic            drain_req;
   logic            stall_o;
   logic            drain_ack;

   logic            pipe_we;
   logic [RW-1:0]   pipe_waddr;
   logic [W-1:0]    pipe_wdata;

   logic            lu_valid;
   logic [RW-1:0]   lu_addr;
   logic [W-1:0]    lu_data;
   logic            lu_ready;

   logic            rf_we;
   logic [RW-1:0]   rf_waddr;
   logic [W-1:0]    rf_wdata;

   logic [NREG-1:0] busy_o;
   logic            sb_err;

   modport master (
      output id_issue, id_rs_en, id_rs_addr, id_rt_en, id_rt_addr, id_wr, id_rd_addr,
             id_long, drain_req, pipe_we, pipe_waddr, pipe_wdata, lu_valid, lu_addr, lu_data,
      input  stall_o, drain_ack, lu_ready, rf_we, rf_waddr, rf_wdata, busy_o, sb_err
   );

   modport slave (
      input  id_issue, id_rs_en, id_rs_addr, id_rt_en, id_rt_addr, id_wr, id_rd_addr,
             id_long, drain_req, pipe_we, pipe_waddr, pipe_wdata, lu_valid, lu_addr, lu_data,
      output stall_o, drain_ack, lu_ready, rf_we, rf_waddr, rf_wdata, busy_o, sb_err
   );
endinterface

// File: rtl/rf_wb_scoreboard.sv
// Single GPR write-port sequencer: WB has priority over the long-latency result channel,
// and a busy scoreboard of pending long writes stalls ID on RAW/WAW hazards.
module rf_wb_scoreboard #(
   parameter int RW         = 5,
   parameter int W          = 32,
   parameter int MAX_PEND   = 4,
   parameter int STARVE_MAX = 8
) (
   input logic               clk,
   input logic               rst,
   rf_wb_scoreboard_if.slave bus
);
   localparam int NREG = 2 ** RW;
   localparam int PW   = $clog2(MAX_PEND + 1);
   localparam int SW   = $clog2(STARVE_MAX + 1);

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DRAIN
   } state_t;

   state_t          state;
   logic [NREG-1:0] busy;
   logic [PW-1:0]   pend;
   logic [SW-1:0]   starve;
   logic            rf_we_q;
   logic [RW-1:0]   rf_waddr_q;
   logic [W-1:0]    rf_wdata_q;
   logic            sb_err_q;

   logic            pwin;
   logic            lu_ready;
   logic            xfer;
   logic            lu_clr;
   logic            sb_set;
   logic            starved;
   logic            hazard;
   logic            stall;
   logic            pend_ovf;
   logic            pend_udf;
   logic            err_evt;
   logic [PW-1:0]   pend_next;
   logic [NREG-1:0] busy_next;

   // NOTE: every signal assigned here gets a default first, so no path leaves it
   // unassigned and no latch is inferred.
   always_comb begin
      pwin      = bus.pipe_we && (bus.pipe_waddr != '0);
      lu_ready  = rst && !pwin;
      xfer      = bus.lu_valid && lu_ready;
      lu_clr    = xfer && (bus.lu_addr != '0);
      starved   = (starve == SW'(STARVE_MAX));

      // Hazards look at the registered scoreboard only; a same-cycle clear does not bypass.
      hazard    = (bus.id_rs_en && (bus.id_rs_addr != '0) && busy[bus.id_rs_addr])
                | (bus.id_rt_en && (bus.id_rt_addr != '0) && busy[bus.id_rt_addr])
                | (bus.id_wr    && (bus.id_rd_addr != '0) && busy[bus.id_rd_addr])
                | (bus.id_long  && (pend == PW'(MAX_PEND)));
      stall     = rst && bus.id_issue && (hazard || starved || (state == DRAIN));

      sb_set    = bus.id_issue && !stall && bus.id_wr && bus.id_long && (bus.id_rd_addr != '0);

      pend_ovf  = sb_set && !lu_clr && (pend == PW'(MAX_PEND));
      pend_udf  = lu_clr && !sb_set && (pend == '0);
      pend_next = pend;
      if (sb_set && !lu_clr && !pend_ovf) begin
         pend_next = pend + PW'(1);
      end else if (lu_clr && !sb_set && !pend_udf) begin
         pend_next = pend - PW'(1);
      end

      // Clear first so that a same-cycle set of the same register wins.
      busy_next = busy;
      if (lu_clr) begin
         busy_next[bus.lu_addr] = 1'b0;
      end
      if (sb_set) begin
         busy_next[bus.id_rd_addr] = 1'b1;
      end

      err_evt   = (lu_clr && !busy[bus.lu_addr])
                | (pwin && busy[bus.pipe_waddr])
                | pend_ovf
                | pend_udf;
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop samples
   // the values from before the edge regardless of statement order.
   always_ff @(posedge clk) begin
      if (!rst) begin
         // NOTE: the busy vector is a small flop array, so it is cleared with everything
         // else; a stale busy bit after reset would stall ID forever.
         state      <= IDLE;
         busy       <= '0;
         pend       <= '0;
         starve     <= '0;
         rf_we_q    <= 1'b0;
         rf_waddr_q <= '0;
         rf_wdata_q <= '0;
         sb_err_q   <= 1'b0;
      end else begin
         if (pwin) begin
            rf_we_q    <= 1'b1;
            rf_waddr_q <= bus.pipe_waddr;
            rf_wdata_q <= bus.pipe_wdata;
         end else if (xfer) begin
            // A result to r0 is consumed but never reaches the file.
            rf_we_q    <= (bus.lu_addr != '0);
            rf_waddr_q <= bus.lu_addr;
            rf_wdata_q <= bus.lu_data;
         end else begin
            rf_we_q    <= 1'b0;
         end

         busy <= busy_next;
         pend <= pend_next;

         if (xfer) begin
            starve <= '0;
         end else if (bus.lu_valid && !starved) begin
            starve <= starve + SW'(1);
         end

         if (err_evt) begin
            sb_err_q <= 1'b1;
         end

         if (bus.drain_req) begin
            state <= DRAIN;
         end else if (pend_next == '0) begin
            state <= IDLE;
         end else begin
            state <= BUSY;
         end
      end
   end

   assign bus.stall_o   = stall;
   assign bus.lu_ready  = lu_ready;
   assign bus.drain_ack = rst && bus.drain_req && (pend == '0);
   assign bus.rf_we     = rf_we_q;
   assign bus.rf_waddr  = rf_waddr_q;
   assign bus.rf_wdata  = rf_wdata_q;
   assign bus.busy_o    = busy;
   assign bus.sb_err    = sb_err_q;
endmodule
